// File: rtl/add_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_mult_pkg
//  Brief    : Shared constants, FSM state type, frame type and parity helper
//             for the add/mult MAC feed controller.
//  Revision : 1.0  initial release
// ============================================================================
package add_mult_pkg;

    localparam int WORD_W        = 32;
    localparam int RES_W_DEF     = 48;
    localparam int NUM_TERMS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        FLUSH   = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    typedef logic [WORD_W-1:0]     word_t;
    typedef word_t [NUM_TERMS_DEF-1:0] frame_t;

    // Even parity: the word plus its parity bit carry an even number of ones.
    function automatic logic parity_ok(input word_t w, input logic p);
        return ~((^w) ^ p);
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_mult_parity_chk.sv
`default_nettype none
// ============================================================================
//  Module   : add_mult_parity_chk
//  Brief    : Per-word even-parity check; zeroes failing words and flags any
//             error. Only present when ADD_MULT_FEED_PARITY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`ifdef ADD_MULT_FEED_PARITY_EN
module add_mult_parity_chk
    import add_mult_pkg::*;
#(
    parameter int NUM_TERMS = NUM_TERMS_DEF
)
(
    input  logic [NUM_TERMS-1:0][WORD_W-1:0] words_i,
    input  logic [NUM_TERMS-1:0]             parity_i,
    output logic [NUM_TERMS-1:0][WORD_W-1:0] words_o,
    output logic                             err_o
);

    logic [NUM_TERMS-1:0] w_bad;

    for (genvar i = 0; i < NUM_TERMS; i++) begin : g_word
        assign w_bad[i]   = ~parity_ok(words_i[i], parity_i[i]);
        assign words_o[i] = w_bad[i] ? '0 : words_i[i];
    end

    assign err_o = |w_bad;

endmodule
`endif
`default_nettype wire

// File: rtl/add_mult_feed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : add_mult_feed_ctrl
//  Brief    : Accepts a frame, steps a MAC through every word, captures the
//             result and holds it until consumed. Optional word parity
//             checking is enabled by defining ADD_MULT_FEED_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module add_mult_feed_ctrl
    import add_mult_pkg::*;
#(
    parameter  int NUM_TERMS = NUM_TERMS_DEF,
    parameter  int RES_W     = RES_W_DEF,
    localparam int IDX_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
)
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_TERMS-1:0][WORD_W-1:0] in_data,
`ifdef ADD_MULT_FEED_PARITY_EN
    input  logic [NUM_TERMS-1:0]             in_parity,
    output logic                             out_perr,
`endif
    output logic [NUM_TERMS-1:0][WORD_W-1:0] mac_data,
    output logic [IDX_W-1:0]                 mac_index,
    output logic                             mac_en,
    input  logic [RES_W-1:0]                 mac_res,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RES_W-1:0]                 out_res
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_TERMS - 1);

    state_t                           state_q, state_d;
    logic [NUM_TERMS-1:0][WORD_W-1:0] data_q, data_d;
    logic [NUM_TERMS-1:0][WORD_W-1:0] w_load_data;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [RES_W-1:0]                 res_q, res_d;
    logic                             valid_q, valid_d;

`ifdef ADD_MULT_FEED_PARITY_EN
    logic perr_q, perr_d;
    logic w_load_err;

    add_mult_parity_chk #(
        .NUM_TERMS (NUM_TERMS)
    ) u_parity_chk (
        .words_i   (in_data),
        .parity_i  (in_parity),
        .words_o   (w_load_data),
        .err_o     (w_load_err)
    );

    assign out_perr = perr_q & valid_q;
`else
    assign w_load_data = in_data;
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        res_d    = res_q;
        valid_d  = valid_q;
        in_ready = 1'b0;
        mac_en   = 1'b0;
`ifdef ADD_MULT_FEED_PARITY_EN
        perr_d   = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = w_load_data;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef ADD_MULT_FEED_PARITY_EN
                    perr_d  = w_load_err;
`endif
                end
            end
            RUN: begin
                mac_en = 1'b1;
                if (idx_q == c_last_idx) begin
                    idx_d   = '0;
                    state_d = FLUSH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            // The MAC latches its sum at the end of FLUSH, so sample one cycle later.
            FLUSH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                res_d   = mac_res;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
`ifdef ADD_MULT_FEED_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            valid_q <= valid_d;
`ifdef ADD_MULT_FEED_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign mac_data  = data_q;
    assign mac_index = idx_q;
    assign out_res   = res_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_add_mult_feed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_mult_feed_ctrl
//  Brief    : Self-checking bench with an attached behavioural MAC.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_mult_feed_ctrl;

    localparam int NT = 8;

    typedef logic [NT-1:0][31:0] frame_t;
    typedef struct {
        frame_t      data;
        int          stall;
        logic [47:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    frame_t       in_data;
    frame_t       mac_data;
    logic [2:0]   mac_index;
    logic         mac_en;
    logic [47:0]  mac_res;
    logic         out_valid;
    logic         out_ready;
    logic [47:0]  out_res;
`ifdef ADD_MULT_FEED_PARITY_EN
    logic [NT-1:0] in_parity;
    logic          out_perr;
`endif

    logic [NT-1:0] bad_mask = '0;
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    add_mult_feed_ctrl #(.NUM_TERMS(NT), .RES_W(48)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef ADD_MULT_FEED_PARITY_EN
        .in_parity (in_parity),
        .out_perr  (out_perr),
`endif
        .mac_data  (mac_data),
        .mac_index (mac_index),
        .mac_en    (mac_en),
        .mac_res   (mac_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    // Bench MAC: two 24-bit lanes, each summing half-word * (index+1);
    // cleared while idle, result latched on the first idle cycle after a run.
    logic [23:0] acc_lo, acc_hi;
    logic        prev_en;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_lo <= '0; acc_hi <= '0; prev_en <= 1'b0; mac_res <= '0;
        end else begin
            prev_en <= mac_en;
            if (mac_en) begin
                acc_lo <= acc_lo + 24'(mac_data[mac_index][15:0])  * (24'(mac_index) + 24'd1);
                acc_hi <= acc_hi + 24'(mac_data[mac_index][31:16]) * (24'(mac_index) + 24'd1);
            end else begin
                if (prev_en) mac_res <= {acc_hi, acc_lo};
                acc_lo <= '0;
                acc_hi <= '0;
            end
        end
    end

    // Reference: weighted sums of the masked frame, plain arithmetic.
    function automatic logic [47:0] model_res(input frame_t f, input logic [NT-1:0] bad);
        longint lo = 0, hi = 0;
        for (int i = 0; i < NT; i++) begin
            if (!bad[i]) begin
                lo += longint'(f[i][15:0])  * (i + 1);
                hi += longint'(f[i][31:16]) * (i + 1);
            end
        end
        return {hi[23:0], lo[23:0]};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_frame(input frame_t f);
        in_data = f;
`ifdef ADD_MULT_FEED_PARITY_EN
        for (int i = 0; i < NT; i++) in_parity[i] = (^f[i]) ^ bad_mask[i];
`endif
    endtask

    // Caller is at a negedge. Offers f, follows it to the out handshake and
    // returns at the negedge right after that handshake.
    task automatic run_frame(input frame_t f, input int stall, input logic [47:0] exp,
                             input bit hold, input frame_t nxt, input string nm);
        frame_t exp_data;
        int     lat;
        int     wt;
        for (int i = 0; i < NT; i++) exp_data[i] = bad_mask[i] ? 32'h0 : f[i];
        drive_frame(f);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        wt = 0;
        while (!in_ready && wt < 50) begin @(negedge clk); wt++; end
        chk({nm, "_accept"}, in_ready, 1);
        if (!in_ready) begin in_valid = 1'b0; return; end
        @(negedge clk);
        lat = 1;
        drive_frame(nxt);
        in_valid = hold;
        while (!out_valid && lat < 40) begin
            chk({nm, "_mac_en"}, mac_en, lat <= NT);
            if (lat <= NT) chk({nm, "_mac_index"}, mac_index, lat - 1);
            chk({nm, "_mac_data"}, mac_data, exp_data);
            chk({nm, "_in_ready_busy"}, in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, NT + 3);
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_out_res"}, out_res, exp);
`ifdef ADD_MULT_FEED_PARITY_EN
        chk({nm, "_out_perr"}, out_perr, |bad_mask);
`endif
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_res"}, out_res, exp);
            chk({nm, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_valid_cleared"}, out_valid, 0);
        chk({nm, "_ready_after_hs"}, in_ready, 1);
    endtask

    vec_t   tbl[5];
    frame_t f1, fz, fa, fb;
    int     wt;
    bit     seen;

    task automatic set_vec(input int k, input frame_t d, input int s, input logic [47:0] e);
        tbl[k].data  = d;
        tbl[k].stall = s;
        tbl[k].exp   = e;
    endtask

    initial begin
        f1 = {NT{32'h00010001}};
        fz = '0;
        set_vec(0, f1, 0, 48'h000024000024);
        set_vec(1, fz, 1, 48'h000000000000);
        set_vec(2, {NT{32'hFFFFFFFF}}, 5, 48'h23FFDC23FFDC);
        for (int i = 0; i < NT; i++) fa[i] = {16'(i + 1), 16'h0000};
        set_vec(3, fa, 2, 48'h0000CC000000);
        fb = '0;
        fb[NT-1] = 32'h00000001;
        set_vec(4, fb, 0, 48'h000000000008);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive_frame(fz);
        repeat (2) @(negedge clk);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_index", mac_index, 0);
        chk("rst_mac_data", mac_data, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        for (int k = 0; k < 5; k++)
            run_frame(tbl[k].data, tbl[k].stall, tbl[k].exp, 1'b0, fz, $sformatf("vec%0d", k));

        // Back-to-back with in_valid held: B waits for A's handshake.
        for (int i = 0; i < NT; i++) fb[i] = {16'(3 * i), 16'(i ^ 5)};
        run_frame(f1, 2, 48'h000024000024, 1'b1, fb, "b2b_a");
        run_frame(fb, 0, model_res(fb, '0), 1'b0, fz, "b2b_b");

        // Reset mid-RUN at index 4.
        drive_frame({NT{32'hFFFFFFFF}});
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wt = 0;
        while (mac_index != 3'd4 && wt < 20) begin @(negedge clk); wt++; end
        chk("rst_run_reach_idx4", mac_index, 4);
        rst = 1'b1;
        #1;
        chk("rst_run_mac_en", mac_en, 0);
        chk("rst_run_mac_index", mac_index, 0);
        chk("rst_run_mac_data", mac_data, 0);
        chk("rst_run_out_res", out_res, 0);
        chk("rst_run_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_run_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (15) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        chk("rst_run_no_partial", seen, 0);
        run_frame(f1, 0, 48'h000024000024, 1'b0, fz, "post_rst");

`ifdef ADD_MULT_FEED_PARITY_EN
        bad_mask = 8'b0000_0100;
        run_frame(f1, 0, 48'h000021000021, 1'b0, fz, "parity");
        bad_mask = '0;
`endif

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NT; i++) fa[i] = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_frame(fa, $urandom_range(0, 3), model_res(fa, bad_mask), 1'b0, fz,
                      $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
